// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and halt/single-step sequencing for the five-stage core.
// Define PIPE_FWD_EN for forwarding/bypass; without it every RAW dependency stalls.
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_de,
    input  logic [4:0]       rs2_de,
    input  logic             rs1_used_de,
    input  logic             rs2_used_de,
    input  logic [4:0]       rs1_ex,
    input  logic [4:0]       rs2_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rd_me,
    input  logic [4:0]       rd_wb,
    input  logic             RuWr_ex,
    input  logic             RuWr_me,
    input  logic             RuWr_wb,
    input  logic             ld_ex,
    input  logic             NextPCSrc_ex,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             clr_cnt,
    output logic             pc_en,
    output logic             fd_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic [1:0]       FwdA_ex,
    output logic [1:0]       FwdB_ex,
    output logic             FwdA_de,
    output logic             FwdB_de,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic hazard_s;
    logic stall_eff_s;
    logic stall_evt_s;
    logic base_pc_en_s;
    logic base_fd_en_s;
    logic base_de_flush_s;

    // x0 is hardwired to zero, so it never produces a dependency
    function automatic logic match_f(input logic [4:0] src, input logic [4:0] rd, input logic wr);
        return wr && (rd != 5'd0) && (src == rd);
    endfunction

`ifdef PIPE_FWD_EN
    // Forward selects, decode bypass and load-use detection
    always_comb begin
        FwdA_ex = 2'b00;
        FwdB_ex = 2'b00;
        if (match_f(rs1_ex, rd_me, RuWr_me)) begin
            FwdA_ex = 2'b01;
        end else if (match_f(rs1_ex, rd_wb, RuWr_wb)) begin
            FwdA_ex = 2'b10;
        end else begin
            FwdA_ex = 2'b00;
        end
        if (match_f(rs2_ex, rd_me, RuWr_me)) begin
            FwdB_ex = 2'b01;
        end else if (match_f(rs2_ex, rd_wb, RuWr_wb)) begin
            FwdB_ex = 2'b10;
        end else begin
            FwdB_ex = 2'b00;
        end
        FwdA_de  = rs1_used_de && match_f(rs1_de, rd_wb, RuWr_wb);
        FwdB_de  = rs2_used_de && match_f(rs2_de, rd_wb, RuWr_wb);
        hazard_s = ld_ex && ((rs1_used_de && match_f(rs1_de, rd_ex, RuWr_ex)) ||
                             (rs2_used_de && match_f(rs2_de, rd_ex, RuWr_ex)));
    end
`else
    logic unused_s;
    assign unused_s = ^{ld_ex, rs1_ex, rs2_ex};

    // No forwarding: any in-flight producer of a used decode source stalls
    always_comb begin
        FwdA_ex  = 2'b00;
        FwdB_ex  = 2'b00;
        FwdA_de  = 1'b0;
        FwdB_de  = 1'b0;
        hazard_s = (rs1_used_de && (match_f(rs1_de, rd_ex, RuWr_ex) ||
                                    match_f(rs1_de, rd_me, RuWr_me) ||
                                    match_f(rs1_de, rd_wb, RuWr_wb))) ||
                   (rs2_used_de && (match_f(rs2_de, rd_ex, RuWr_ex) ||
                                    match_f(rs2_de, rd_me, RuWr_me) ||
                                    match_f(rs2_de, rd_wb, RuWr_wb)));
    end
`endif

    // A taken branch squashes the dependent instruction, so it is not a stall
    assign stall_eff_s = hazard_s && !NextPCSrc_ex;
    assign stall_evt_s = stall_eff_s && (state_r != ST_HALT);
    assign halted      = (state_r == ST_HALT);

    // Debug FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and pipeline enables; branch beats hazard and halt hold
    always_comb begin
        state_next_s    = state_r;
        base_pc_en_s    = 1'b1;
        base_fd_en_s    = 1'b1;
        base_de_flush_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                state_next_s    = halt_req ? ST_HALT : ST_RUN;
                base_pc_en_s    = !stall_eff_s;
                base_fd_en_s    = !stall_eff_s;
                base_de_flush_s = stall_eff_s;
            end
            ST_HALT: begin
                base_pc_en_s    = 1'b0;
                base_fd_en_s    = 1'b0;
                base_de_flush_s = 1'b1;
                if (step_req) begin
                    state_next_s = ST_STEP;
                end else if (!halt_req) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_STEP: begin
                base_pc_en_s    = !stall_eff_s;
                base_fd_en_s    = !stall_eff_s;
                base_de_flush_s = stall_eff_s;
                if (stall_eff_s) begin
                    state_next_s = ST_STEP;
                end else if (halt_req) begin
                    state_next_s = ST_HALT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            default: begin
                state_next_s    = ST_RUN;
                base_pc_en_s    = 1'b0;
                base_fd_en_s    = 1'b0;
                base_de_flush_s = 1'b1;
            end
        endcase

        if (rst) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (NextPCSrc_ex) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else begin
            pc_en    = base_pc_en_s;
            fd_en    = base_fd_en_s;
            fd_flush = 1'b0;
            de_flush = base_de_flush_s;
        end
    end

    // Saturating stall counter, clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            stall_count <= {CNT_W{1'b0}};
        end else if (stall_evt_s && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count <= stall_count;
        end
    end

    // Saturating flush counter, clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_count <= {CNT_W{1'b0}};
        end else if (clr_cnt) begin
            flush_count <= {CNT_W{1'b0}};
        end else if (NextPCSrc_ex && (flush_count != {CNT_W{1'b1}})) begin
            flush_count <= flush_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            flush_count <= flush_count;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (CNT_W=4); expectations
// follow PIPE_FWD_EN when it is defined, otherwise the stall-only build.
module tb_pipe_hazard_ctrl;

`ifdef PIPE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_de, rs2_de, rs1_ex, rs2_ex, rd_ex, rd_me, rd_wb;
    logic rs1_used_de, rs2_used_de, RuWr_ex, RuWr_me, RuWr_wb, ld_ex;
    logic NextPCSrc_ex, halt_req, step_req, clr_cnt;
    logic pc_en, fd_en, fd_flush, de_flush, FwdA_de, FwdB_de, halted;
    logic [1:0] FwdA_ex, FwdB_ex;
    logic [CNT_W-1:0] stall_count, flush_count;

    int n_run = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1_de(rs1_de), .rs2_de(rs2_de),
        .rs1_used_de(rs1_used_de), .rs2_used_de(rs2_used_de),
        .rs1_ex(rs1_ex), .rs2_ex(rs2_ex),
        .rd_ex(rd_ex), .rd_me(rd_me), .rd_wb(rd_wb),
        .RuWr_ex(RuWr_ex), .RuWr_me(RuWr_me), .RuWr_wb(RuWr_wb),
        .ld_ex(ld_ex), .NextPCSrc_ex(NextPCSrc_ex),
        .halt_req(halt_req), .step_req(step_req), .clr_cnt(clr_cnt),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_flush(de_flush),
        .FwdA_ex(FwdA_ex), .FwdB_ex(FwdB_ex), .FwdA_de(FwdA_de), .FwdB_de(FwdB_de),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_in();
        rs1_de = 5'd0; rs2_de = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
        rd_ex = 5'd0; rd_me = 5'd0; rd_wb = 5'd0;
        rs1_used_de = 1'b0; rs2_used_de = 1'b0;
        RuWr_ex = 1'b0; RuWr_me = 1'b0; RuWr_wb = 1'b0; ld_ex = 1'b0;
        NextPCSrc_ex = 1'b0; halt_req = 1'b0; step_req = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic set_load_use();
        ld_ex = 1'b1; RuWr_ex = 1'b1; rd_ex = 5'd6;
        rs2_de = 5'd6; rs2_used_de = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_in();
        #2;
        chk("rst_pc_en", 32'(pc_en), 32'd0);
        chk("rst_fd_en", 32'(fd_en), 32'd0);
        chk("rst_fd_flush", 32'(fd_flush), 32'd1);
        chk("rst_de_flush", 32'(de_flush), 32'd1);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall_cnt", 32'(stall_count), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("run_pc_en", 32'(pc_en), 32'd1);
        chk("run_fd_en", 32'(fd_en), 32'd1);
        chk("run_fd_flush", 32'(fd_flush), 32'd0);
        chk("run_de_flush", 32'(de_flush), 32'd0);
        chk("run_fwda", 32'(FwdA_ex), 32'd0);

        // Execute-stage forwarding
        rs1_ex = 5'd5; rd_me = 5'd5; RuWr_me = 1'b1;
        #1 chk("fwda_me", 32'(FwdA_ex), FWD ? 32'd1 : 32'd0);
        rd_me = 5'd0;
        #1 chk("fwda_x0", 32'(FwdA_ex), 32'd0);
        rs2_ex = 5'd9; rd_me = 5'd9; rd_wb = 5'd9; RuWr_wb = 1'b1;
        #1 chk("fwdb_me_wins", 32'(FwdB_ex), FWD ? 32'd1 : 32'd0);
        RuWr_me = 1'b0;
        #1 chk("fwdb_wb", 32'(FwdB_ex), FWD ? 32'd2 : 32'd0);
        rs1_de = 5'd9; rs1_used_de = 1'b1;
        #1 chk("fwda_de", 32'(FwdA_de), FWD ? 32'd1 : 32'd0);
        clear_in();
        tick();

        // Load-use stall
        set_load_use();
        #1;
        chk("lu_pc_en", 32'(pc_en), 32'd0);
        chk("lu_fd_en", 32'(fd_en), 32'd0);
        chk("lu_de_flush", 32'(de_flush), 32'd1);
        chk("lu_fd_flush", 32'(fd_flush), 32'd0);
        tick();
        clear_in();
        #1;
        chk("lu_stall_cnt", 32'(stall_count), 32'd1);
        chk("lu_released", 32'(pc_en), 32'd1);

        // Branch overrides a load-use stall
        set_load_use();
        NextPCSrc_ex = 1'b1;
        #1;
        chk("br_pc_en", 32'(pc_en), 32'd1);
        chk("br_fd_flush", 32'(fd_flush), 32'd1);
        chk("br_de_flush", 32'(de_flush), 32'd1);
        tick();
        clear_in();
        #1;
        chk("br_flush_cnt", 32'(flush_count), 32'd1);
        chk("br_stall_cnt", 32'(stall_count), 32'd1);

        // Halt for five cycles, then one step
        halt_req = 1'b1;
        #1 chk("halt_not_yet", 32'(halted), 32'd0);
        tick();
        chk("halt_halted", 32'(halted), 32'd1);
        chk("halt_pc_en", 32'(pc_en), 32'd0);
        chk("halt_de_flush", 32'(de_flush), 32'd1);
        tick(); tick(); tick();
        step_req = 1'b1;
        #1 chk("halt_step_req_pc", 32'(pc_en), 32'd0);
        tick();
        step_req = 1'b0;
        #1;
        chk("step_pc_en", 32'(pc_en), 32'd1);
        chk("step_fd_en", 32'(fd_en), 32'd1);
        chk("step_de_flush", 32'(de_flush), 32'd0);
        chk("step_halted", 32'(halted), 32'd0);
        tick();
        chk("rehalt_pc_en", 32'(pc_en), 32'd0);
        chk("rehalt_halted", 32'(halted), 32'd1);
        halt_req = 1'b0;
        #1 chk("unhalt_wait", 32'(halted), 32'd1);
        tick();
        chk("unhalt_halted", 32'(halted), 32'd0);
        chk("unhalt_pc_en", 32'(pc_en), 32'd1);
        chk("halt_no_count", 32'(stall_count), 32'd1);

        // Step held by a load-use stall
        halt_req = 1'b1;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        set_load_use();
        #1 chk("step_lu_pc_en", 32'(pc_en), 32'd0);
        tick();
        ld_ex = 1'b0; RuWr_ex = 1'b0; rd_ex = 5'd0; rs2_de = 5'd0; rs2_used_de = 1'b0;
        #1;
        chk("step_held_halted", 32'(halted), 32'd0);
        chk("step_held_pc_en", 32'(pc_en), 32'd1);
        tick();
        chk("step_done_halted", 32'(halted), 32'd1);
        chk("step_lu_cnt", 32'(stall_count), 32'd2);

        // Asynchronous reset while halted
        rst = 1'b1;
        #1;
        chk("rst_mid_halted", 32'(halted), 32'd0);
        chk("rst_mid_pc_en", 32'(pc_en), 32'd0);
        clear_in();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_mid_run", 32'(pc_en), 32'd1);
        chk("rst_mid_cnt", 32'(stall_count), 32'd0);

        // Saturation and clear priority
        set_load_use();
        NextPCSrc_ex = 1'b1;
        tick();
        NextPCSrc_ex = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        chk("sat_reach", 32'(stall_count), 32'd15);
        tick();
        chk("sat_hold", 32'(stall_count), 32'd15);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        chk("clr_stall", 32'(stall_count), 32'd0);
        chk("clr_flush", 32'(flush_count), 32'd0);
        clear_in();
        tick();

        // ALU producer x7 followed by a dependent in decode
        rd_ex = 5'd7; RuWr_ex = 1'b1; rs1_de = 5'd7; rs1_used_de = 1'b1;
        #1;
        chk("dep_ex_pc_en", 32'(pc_en), FWD ? 32'd1 : 32'd0);
        chk("dep_ex_fwda", 32'(FwdA_ex), 32'd0);
        tick();
        rd_ex = 5'd0; RuWr_ex = 1'b0; rd_me = 5'd7; RuWr_me = 1'b1;
        #1;
        chk("dep_me_pc_en", 32'(pc_en), FWD ? 32'd1 : 32'd0);
        chk("dep_me_fwda", 32'(FwdA_ex), 32'd0);
        tick();
        rd_me = 5'd0; RuWr_me = 1'b0; rd_wb = 5'd7; RuWr_wb = 1'b1;
        #1;
        chk("dep_wb_pc_en", 32'(pc_en), FWD ? 32'd1 : 32'd0);
        chk("dep_wb_fwda", 32'(FwdA_ex), 32'd0);
        tick();
        rd_wb = 5'd0; RuWr_wb = 1'b0;
        #1;
        chk("dep_done_pc_en", 32'(pc_en), 32'd1);
        chk("dep_stall_cnt", 32'(stall_count), FWD ? 32'd0 : 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Sequencing and hazard controller for the five-stage pipelined core (fetch, decode, execute, memory, writeback). Every cycle it decides whether the PC and fetch/decode registers advance, hold or flush, and whether a bubble enters execute. It drives the execute-stage and decode-stage forwarding selects and runs a halt/single-step debug state machine. Saturating counters expose stall and flush activity.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous active-high reset
- rs1_de, rs2_de  in  5  source register fields of the instruction in decode
- rs1_used_de, rs2_used_de  in  1  decode instruction actually reads rs1/rs2
- rs1_ex, rs2_ex  in  5  source fields of the instruction in execute
- rd_ex, rd_me, rd_wb  in  5  destination register per stage
- RuWr_ex, RuWr_me, RuWr_wb  in  1  register-write enable per stage
- ld_ex  in  1  instruction in execute is a load (RUDatawrSrc_ex selects memory data)
- NextPCSrc_ex  in  1  taken branch or jump resolved in execute
- halt_req  in  1  level request to halt fetch
- step_req  in  1  single-cycle pulse to release one instruction while halted
- clr_cnt  in  1  synchronous clear of both counters
- pc_en  out  1  PC register load enable
- fd_en  out  1  fetch/decode pipeline register enable
- fd_flush  out  1  load NOP (0x00000013) into fetch/decode registers
- de_flush  out  1  zero the decode/execute control registers (bubble)
- FwdA_ex, FwdB_ex  out  2  ALU operand source: 00 register, 01 ALURes_me, 10 DataWr_wb
- FwdA_de, FwdB_de  out  1  replace RUrs1_de/RUrs2_de with DataWr_wb
- halted  out  1  FSM in HALT
- stall_count, flush_count  out  CNT_W  saturating event counters

## Operation
- Match(s, rd, wr) = wr && rd != 0 && s == rd. Register x0 never creates a hazard or a forward.
- Execute forwarding: Match(rs1_ex, rd_me, RuWr_me) gives FwdA_ex=01. Otherwise Match(rs1_ex, rd_wb, RuWr_wb) gives 10. Otherwise 00. The memory stage wins over writeback. FwdB_ex is the same using rs2_ex.
- Decode bypass: FwdA_de = rs1_used_de && Match(rs1_de, rd_wb, RuWr_wb). This covers the register file writing at the same edge that latches the decode read. FwdB_de is the same using rs2.
- Load-use: ld_ex && (rs1_used_de && Match(rs1_de, rd_ex, RuWr_ex) || rs2_used_de && Match(rs2_de, rd_ex, RuWr_ex)) produces a hazard stall: pc_en=0, fd_en=0, de_flush=1 for one cycle.
- Taken branch: NextPCSrc_ex=1 gives pc_en=1, fd_flush=1, de_flush=1. The branch overrides a simultaneous load-use stall and any halt hold.
- FSM states:
  - RUN:
    - Normal operation.
    - halt_req=1 moves to HALT at the next edge.
  - HALT:
    - Outputs pc_en=0, fd_en=0, de_flush=1, so in-flight instructions drain.
    - step_req=1 moves to STEP.
    - Otherwise halt_req=0 moves to RUN.
    - step_req has priority when both apply.
  - STEP:
    - Lasts one cycle, with pc_en=fd_en=1 and de_flush=0 unless a hazard applies.
    - Moves to RUN if halt_req=0, else back to HALT.
    - A load-use stall in STEP keeps the FSM in STEP until the stall clears.
- Counters:
  - stall_count increments every cycle with a hazard stall. Halt holds do not count.
  - flush_count increments every cycle with NextPCSrc_ex=1.
  - Both saturate at all-ones.
  - clr_cnt clears them and has priority over an increment in the same cycle.

## Timing
- During rst and after reset:
  - While rst is high: state RUN, halted=0, counters 0, pc_en=0, fd_en=0, fd_flush=1, de_flush=1.
  - After rst deasserts: all enables 1, flushes 0, forwards 0.
- Hazard, forward and flush outputs are combinational from current inputs and state, valid in the same cycle, with zero latency.
- halted rises at the first edge after halt_req is sampled high. It falls one cycle after halt_req is sampled low in HALT.
- A step releases exactly one fetch: the PC advances at one edge only, unless a taken branch occurs.
- Asserting rst mid-stall or mid-step returns to RUN immediately. No pending state survives.

## Configuration
- PIPE_FWD_EN defined:
  - Forwarding and decode bypass are active as described.
  - Only load-use causes hazard stalls.
- PIPE_FWD_EN undefined:
  - FwdA_ex/FwdB_ex are tied to 00 and FwdA_de/FwdB_de to 0.
  - Any used decode source matching an ex, me or wb producer stalls, for up to three cycles.
  - stall_count counts each of those cycles.

## Test plan
- add x5 in execute, then add using x5 in execute while the producer is in memory (rs1_ex=5, rd_me=5, RuWr_me=1) -> FwdA_ex=01. With rd_me=0 -> FwdA_ex=00.
- Load to x6 (ld_ex=1, rd_ex=6) with decode rs2_de=6, rs2_used_de=1 -> exactly one cycle of pc_en=0, fd_en=0, de_flush=1, and stall_count goes 0->1.
- NextPCSrc_ex=1 in the same cycle as a load-use match -> pc_en=1, fd_flush=1, de_flush=1; flush_count +1, stall_count unchanged.
- halt_req=1 for 5 cycles, then step_req pulse -> halted=1 from the next edge and pc_en high for exactly one cycle; halt_req=0 -> RUN, halted=0.
- Preload stall_count to all-ones (CNT_W=4, 15) and cause another stall -> stays 15; clr_cnt with a stall in the same cycle -> 0.
- PIPE_FWD_EN undefined: add x7 then dependent add in decode -> 3 stall cycles and FwdA_ex=00 throughout.
